// File: rtl/gpu_pkg.sv
// gpu_pkg: core phase codes, fetcher states and opcodes shared by the fetcher and decoder
package gpu_pkg;
   localparam logic [2:0] CORE_IDLE   = 3'b000;
   localparam logic [2:0] CORE_FETCH  = 3'b001;
   localparam logic [2:0] CORE_DECODE = 3'b010;
   typedef enum logic [1:0] {
      FETCHER_IDLE     = 2'b00,
      FETCHER_FETCHING = 2'b01,
      FETCHER_FETCHED  = 2'b10
   } fetcher_state_t;
   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_RET = 4'b1111;
   localparam logic [15:0] NOP_INSTR = {OP_NOP, 12'h000};
   localparam logic [15:0] RET_INSTR = {OP_RET, 12'h000};
endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: saturating wait counter that flags the last permitted cycle of a memory wait
module fetch_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic expired
);
   localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   logic [CW-1:0] cnt;
   assign expired = (TIMEOUT_CYCLES != 0) && run && (cnt == LAST);
   // count waiting cycles, held at zero outside a wait and saturating at all-ones
   always_ff @(posedge clk)
      cnt <= (!reset || clear) ? '0 : (run && cnt != '1) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/instr_fetcher.sv
// instr_fetcher: issues one program-memory read per FETCH phase and holds the word for decode
module instr_fetcher
   import gpu_pkg::*;
#(
   parameter int PROGRAM_MEM_ADDR_BITS = 8,
   parameter int PROGRAM_MEM_DATA_BITS = 16,
   parameter int TIMEOUT_CYCLES        = 255
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [2:0]                       core_state,
   input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
   output logic                             mem_read_valid,
   output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
   input  logic                             mem_read_ready,
   input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
   output logic [1:0]                       fetcher_state,
   output logic [PROGRAM_MEM_DATA_BITS-1:0] instr,
   output logic                             fetch_error
);
   fetcher_state_t state;
   logic expired;
   assign fetcher_state = state;
   fetch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .clk(clk),
      .reset(reset),
      .run(state == FETCHER_FETCHING),
      .clear(state != FETCHER_FETCHING),
      .expired(expired)
   );
   // request/capture FSM; a response beats a coinciding watchdog expiry
   always_ff @(posedge clk)
      if (!reset) begin
         state            <= FETCHER_IDLE;
         mem_read_valid   <= 1'b0;
         mem_read_address <= '0;
         instr            <= PROGRAM_MEM_DATA_BITS'(NOP_INSTR);
         fetch_error      <= 1'b0;
      end else
         case (state)
            FETCHER_IDLE:
               if (core_state == CORE_FETCH) begin
                  state            <= FETCHER_FETCHING;
                  mem_read_valid   <= 1'b1;
                  mem_read_address <= current_pc;
               end
            FETCHER_FETCHING:
               if (mem_read_valid && mem_read_ready) begin
                  instr          <= mem_read_data;
                  mem_read_valid <= 1'b0;
                  state          <= FETCHER_FETCHED;
               end else if (expired) begin
                  instr          <= PROGRAM_MEM_DATA_BITS'(RET_INSTR);
                  fetch_error    <= 1'b1;
                  mem_read_valid <= 1'b0;
                  state          <= FETCHER_FETCHED;
               end
            FETCHER_FETCHED:
               if (core_state == CORE_DECODE) state <= FETCHER_IDLE;
            default:
               state <= FETCHER_IDLE;
         endcase
endmodule

// File: tb/tb_instr_fetcher.sv
// tb_instr_fetcher: directed and randomized fetch transactions checked against a transaction-level model
module tb_instr_fetcher;
   localparam int TO = 4;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  core_state = 3'b000;
   logic [7:0]  current_pc = 8'h00;
   logic        mem_read_valid;
   logic [7:0]  mem_read_address;
   logic        mem_read_ready = 1'b0;
   logic [15:0] mem_read_data = 16'h0000;
   logic [1:0]  fetcher_state;
   logic [15:0] instr;
   logic        fetch_error;
   int checks = 0;
   int errors = 0;
   logic [15:0] exp_instr = 16'h0000;
   logic        exp_err = 1'b0;

   instr_fetcher #(.PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(16), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk),
      .reset(reset),
      .core_state(core_state),
      .current_pc(current_pc),
      .mem_read_valid(mem_read_valid),
      .mem_read_address(mem_read_address),
      .mem_read_ready(mem_read_ready),
      .mem_read_data(mem_read_data),
      .fetcher_state(fetcher_state),
      .instr(instr),
      .fetch_error(fetch_error)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".state"}, 32'(fetcher_state), 32'h0);
      chk({tag, ".valid"}, 32'(mem_read_valid), 32'h0);
      chk({tag, ".instr"}, 32'(instr), 32'(exp_instr));
      chk({tag, ".err"}, 32'(fetch_error), 32'(exp_err));
   endtask

   // one full transaction: request, response after d cycles (or watchdog), linger, decode
   task automatic fetch(input logic [7:0] pc, input logic [15:0] data, input int d, input bit hold_fetch);
      int done;
      logic [15:0] new_instr;
      core_state = 3'b001;
      current_pc = pc;
      mem_read_ready = 1'b0;
      step();
      chk("req.state", 32'(fetcher_state), 32'h1);
      chk("req.valid", 32'(mem_read_valid), 32'h1);
      chk("req.addr", 32'(mem_read_address), 32'(pc));
      current_pc = pc ^ 8'hA5;
      core_state = 3'($urandom_range(0, 7));
      done = (d < TO) ? d : TO - 1;
      new_instr = (d < TO) ? data : 16'hF000;
      for (int k = 0; k <= done; k++) begin
         mem_read_ready = (k == d);
         mem_read_data = (k == d) ? data : 16'($urandom);
         step();
         if (k < done) begin
            chk("wait.state", 32'(fetcher_state), 32'h1);
            chk("wait.valid", 32'(mem_read_valid), 32'h1);
            chk("wait.addr", 32'(mem_read_address), 32'(pc));
            chk("wait.instr", 32'(instr), 32'(exp_instr));
            chk("wait.err", 32'(fetch_error), 32'(exp_err));
         end
      end
      exp_instr = new_instr;
      if (d >= TO) exp_err = 1'b1;
      chk("done.state", 32'(fetcher_state), 32'h2);
      chk("done.valid", 32'(mem_read_valid), 32'h0);
      chk("done.instr", 32'(instr), 32'(exp_instr));
      chk("done.err", 32'(fetch_error), 32'(exp_err));
      for (int n = hold_fetch ? 3 : int'($urandom_range(0, 3)); n > 0; n--) begin
         core_state = hold_fetch ? 3'b001 : 3'($urandom_range(0, 6));
         if (core_state >= 3'b010) core_state = core_state + 3'b001;
         mem_read_ready = 1'($urandom);
         mem_read_data = 16'($urandom);
         step();
         chk("held.state", 32'(fetcher_state), 32'h2);
         chk("held.valid", 32'(mem_read_valid), 32'h0);
         chk("held.instr", 32'(instr), 32'(exp_instr));
      end
      core_state = 3'b010;
      mem_read_ready = 1'($urandom);
      step();
      chk_idle("decode");
      core_state = 3'b000;
      mem_read_ready = 1'b0;
      step();
      chk_idle("idle");
   endtask

   initial begin
      reset = 1'b0;
      core_state = 3'b001;
      mem_read_ready = 1'b1;
      repeat (2) step();
      chk_idle("reset");
      chk("reset.addr", 32'(mem_read_address), 32'h0);
      reset = 1'b1;
      core_state = 3'b000;
      mem_read_ready = 1'b0;
      step();
      chk_idle("post_reset");
      fetch(8'h05, 16'h3123, 3, 1'b0);
      fetch(8'h05, 16'h4ABC, 0, 1'b0);
      for (int i = 0; i < 20; i++)
         fetch(8'($urandom), 16'($urandom), int'($urandom_range(0, TO - 1)), 1'b0);
      fetch(8'h22, 16'h1234, TO + 2, 1'b0);
      fetch(8'h23, 16'h5678, 1, 1'b1);
      for (int i = 0; i < 20; i++)
         fetch(8'($urandom), 16'($urandom), int'($urandom_range(0, TO + 2)), 1'b0);
      core_state = 3'b001;
      current_pc = 8'h40;
      step();
      chk("rst_mid.state", 32'(fetcher_state), 32'h1);
      reset = 1'b0;
      step();
      exp_instr = 16'h0000;
      exp_err = 1'b0;
      chk_idle("rst_mid");
      chk("rst_mid.addr", 32'(mem_read_address), 32'h0);
      reset = 1'b1;
      core_state = 3'b000;
      mem_read_ready = 1'b1;
      mem_read_data = 16'hBEEF;
      step();
      chk_idle("late_ready");
      mem_read_ready = 1'b0;
      fetch(8'h77, 16'h9001, 2, 1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/instr_fetcher.md
Name: instr_fetcher

Overview:
- Front end of the per-core instruction path.
- On each core FETCH phase it issues one read request to program memory at the current PC, waits through a valid/ready handshake, and captures the returned 16-bit word.
- It holds that word on `instr` for the instruction decoder, which samples it during the DECODE phase.
- A bounded-wait watchdog substitutes a RET when memory never answers, so the core always terminates.

Parameters:
- PROGRAM_MEM_ADDR_BITS, 8, program memory address width.
- PROGRAM_MEM_DATA_BITS, 16, instruction width.
- TIMEOUT_CYCLES, 255, maximum FETCHING cycles without ready before abort; 0 disables the watchdog.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- core_state  in  3  core phase: 000 IDLE, 001 FETCH, 010 DECODE; other codes ignored by this block
- current_pc  in  PROGRAM_MEM_ADDR_BITS  address of the next instruction
- mem_read_valid  out  1  read request to program memory
- mem_read_address  out  PROGRAM_MEM_ADDR_BITS  request address
- mem_read_ready  in  1  memory response strobe
- mem_read_data  in  PROGRAM_MEM_DATA_BITS  response data, valid while mem_read_ready=1
- fetcher_state  out  2  00 IDLE, 01 FETCHING, 10 FETCHED
- instr  out  PROGRAM_MEM_DATA_BITS  captured instruction
- fetch_error  out  1  sticky watchdog flag

Behaviour:
- One clock. Reset is synchronous and active-low: sampled on posedge clk when reset==0.
- Reset values:
  - fetcher_state=IDLE
  - mem_read_valid=0
  - mem_read_address=0
  - instr=0 (NOP)
  - fetch_error=0
  - wait counter=0
- Reset mid-handshake drops the request immediately at that edge. A mem_read_ready arriving later is ignored.
- IDLE:
  - If core_state==FETCH at edge T, then at T+1: FETCHING, mem_read_valid=1, mem_read_address=current_pc (sampled at T), counter=0.
  - Otherwise stay in IDLE.
- FETCHING:
  - mem_read_valid and mem_read_address are held stable until completion.
  - mem_read_ready is only honoured while mem_read_valid=1.
  - If mem_read_ready==1 at edge E: instr<=mem_read_data, mem_read_valid<=0, state<=FETCHED.
  - Minimum latency: FETCH seen at T, valid at T+1, ready at T+1, FETCHED and instr valid at T+2.
  - Otherwise the counter increments, saturating at the counter maximum.
  - With TIMEOUT_CYCLES≠0, if counter==TIMEOUT_CYCLES-1 and ready==0 at edge E:
    - instr<=RET encoding (opcode 4'b1111, rest 0 → 16'hF000)
    - fetch_error<=1
    - mem_read_valid<=0
    - state<=FETCHED
  - If ready and timeout coincide at the same edge, ready wins: data captured, no error.
- FETCHED:
  - instr is held stable.
  - If core_state==DECODE at edge, next state is IDLE.
  - Any other core_state: stay in FETCHED. No new request is issued, even if core_state returns to FETCH.
- instr holds its value in IDLE until the next capture. The decoder may sample it one cycle after the FETCHED→IDLE transition.
- fetch_error clears only on reset.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.
- current_pc changes while in FETCHING are ignored; the address was latched at request.
- Unused fetcher_state code 11 is treated as IDLE on the next edge.

Decomposition:
- Shared package gpu_pkg holds:
  - core_state localparams (IDLE/FETCH/DECODE…)
  - fetcher_state enum
  - opcode constants, including RET=4'b1111 and NOP=4'b0000, shared with the decoder
  - the RET_INSTR constant
- Optional sub-module fetch_watchdog: counter plus expiry compare, with ports clk, reset, run, clear, expired.

Test Plan:
1. Reset (reset=0 for 2 cycles) → all outputs 0, fetcher_state=00.
2. current_pc=8'h05, core_state=FETCH; memory returns 16'h3123 with ready 3 cycles after valid:
   - valid and address=05 held stable for 3 cycles
   - instr=16'h3123 and FETCHED one edge after ready
   - core_state=DECODE → IDLE next edge
3. Zero-wait: ready asserted the same cycle valid rises → FETCHED at T+2; change current_pc to 8'h06 while FETCHING → address stays 05.
4. TIMEOUT_CYCLES=4, ready held 0:
   - after 4 FETCHING cycles, instr=16'hF000, fetch_error=1, valid=0
   - fetch_error stays 1 through the next successful fetch
5. TIMEOUT_CYCLES=4, ready first asserted on the 4th FETCHING cycle (the expiry edge) → data captured, fetch_error stays 0.
6. Assert reset while FETCHING, then pulse ready the cycle after → state IDLE, instr=0, no capture; stay in FETCHED while core_state=FETCH lingers → no second request issued.
